// File: rtl/cm_config_sequencer.sv
// Color Manager configuration bus master.
// Replays a fixed boot sequence after reset, then arbitrates round-robin between two requesters
// and issues each write as a one-cycle active-low strobe, waiting for an active-low acknowledge
// with a timeout.
// Optional feature macro: CM_CFG_RETRY_EN. When defined, a timed-out write is reissued up to
// MAX_RETRY times before it is dropped.
module cm_config_sequencer #(
    parameter int unsigned                    C_ADDR_WIDTH     = 4,
    parameter int unsigned                    C_DATA_WIDTH     = 16,
    parameter logic [C_ADDR_WIDTH-1:0]        ADDR_VGA_CONFIG  = C_ADDR_WIDTH'(1),
    parameter logic [C_ADDR_WIDTH-1:0]        ADDR_VGA_COLOR   = C_ADDR_WIDTH'(2),
    parameter logic [C_ADDR_WIDTH-1:0]        ADDR_VGA_QUADRAN = C_ADDR_WIDTH'(3),
    parameter logic [C_DATA_WIDTH-1:0]        BOOT_RES         = C_DATA_WIDTH'(0),
    parameter logic [C_DATA_WIDTH-3:0]        BOOT_COLOR_LU    = 14'h3FFF,
    parameter logic [C_DATA_WIDTH-3:0]        BOOT_COLOR_RU    = 14'h0FC0,
    parameter logic [C_DATA_WIDTH-3:0]        BOOT_COLOR_LD    = 14'h003F,
    parameter logic [C_DATA_WIDTH-3:0]        BOOT_COLOR_RD    = 14'h0000,
    parameter logic [C_DATA_WIDTH-1:0]        BOOT_QUAD        = C_DATA_WIDTH'(3),
    parameter int unsigned                    TIMEOUT          = 15,
    parameter int unsigned                    TIMEOUT_WIDTH    = 4,
    parameter int unsigned                    MAX_RETRY        = 2
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic                    Req_A_Valid,
    input  logic [C_ADDR_WIDTH-1:0] Req_A_Addr,
    input  logic [C_DATA_WIDTH-1:0] Req_A_Data,
    output logic                    Req_A_Ack,
    input  logic                    Req_B_Valid,
    input  logic [C_ADDR_WIDTH-1:0] Req_B_Addr,
    input  logic [C_DATA_WIDTH-1:0] Req_B_Data,
    output logic                    Req_B_Ack,
    output logic [C_ADDR_WIDTH-1:0] C_Addr,
    output logic [C_DATA_WIDTH-1:0] C_Data,
    output logic                    C_Valid,
    input  logic                    C_Rdy,
    output logic                    Busy,
    output logic                    Boot_Done,
    output logic                    Err_Timeout,
    output logic [3:0]              Err_Count
);

    typedef enum logic [2:0] {
        StBootIssue,
        StBootWait,
        StIdle,
        StIssue,
        StWait
    } state_e;

    localparam logic [TIMEOUT_WIDTH-1:0] LastWaitCnt = TIMEOUT_WIDTH'(TIMEOUT - 1);
    localparam logic [2:0]               BootLast    = 3'd5;

    state_e                    state_q, state_d;
    logic [2:0]                boot_idx_q, boot_idx_d;
    logic                      rr_q, rr_d;  // last granted requester: 0 = A, 1 = B
    logic [TIMEOUT_WIDTH-1:0]  wait_cnt_q, wait_cnt_d;
    logic [C_ADDR_WIDTH-1:0]   c_addr_q, c_addr_d;
    logic [C_DATA_WIDTH-1:0]   c_data_q, c_data_d;
    logic                      c_valid_q, c_valid_d;
    logic                      ack_a_q, ack_a_d;
    logic                      ack_b_q, ack_b_d;
    logic                      err_timeout_q, err_timeout_d;
    logic [3:0]                err_count_q, err_count_d;
    logic                      boot_done_q, boot_done_d;

    logic [C_ADDR_WIDTH-1:0]   boot_addr;
    logic [C_DATA_WIDTH-1:0]   boot_data;
    logic                      grant_b;
    logic                      finish;   // current write is complete (acked or dropped)
    logic                      drop;     // current write is abandoned after timeout
    logic                      reissue;  // current write is retried
    logic                      retry_ok;

`ifdef CM_CFG_RETRY_EN
    localparam int unsigned RetryW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RetryW-1:0] RetryMax = RetryW'(MAX_RETRY);

    logic [RetryW-1:0] retry_q, retry_d;

    // Retry counter: advances on each reissue, clears once a write finishes.
    always_comb begin
        retry_d = retry_q;
        if (reissue) begin
            retry_d = retry_q + 1'b1;
        end else if (finish) begin
            retry_d = '0;
        end
    end

    assign retry_ok = (retry_q != RetryMax);

    // Retry counter register.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            retry_q <= '0;
        end else begin
            retry_q <= retry_d;
        end
    end
`else
    assign retry_ok = 1'b0;
`endif

    // Boot table lookup; colour entries carry the quadrant in the top two data bits.
    always_comb begin
        boot_addr = ADDR_VGA_COLOR;
        boot_data = '0;
        case (boot_idx_q)
            3'd0: begin
                boot_addr = ADDR_VGA_CONFIG;
                boot_data = BOOT_RES;
            end
            3'd1:    boot_data = {2'b00, BOOT_COLOR_LU};
            3'd2:    boot_data = {2'b01, BOOT_COLOR_RU};
            3'd3:    boot_data = {2'b10, BOOT_COLOR_LD};
            3'd4:    boot_data = {2'b11, BOOT_COLOR_RD};
            default: begin
                boot_addr = ADDR_VGA_QUADRAN;
                boot_data = BOOT_QUAD;
            end
        endcase
    end

    // Both valid: grant the requester that was not granted last.
    assign grant_b = Req_B_Valid && (!Req_A_Valid || !rr_q);

    // Next-state and registered-output computation.
    always_comb begin
        state_d       = state_q;
        boot_idx_d    = boot_idx_q;
        rr_d          = rr_q;
        wait_cnt_d    = wait_cnt_q;
        c_addr_d      = c_addr_q;
        c_data_d      = c_data_q;
        c_valid_d     = 1'b1;
        ack_a_d       = 1'b0;
        ack_b_d       = 1'b0;
        err_timeout_d = 1'b0;
        err_count_d   = err_count_q;
        boot_done_d   = boot_done_q;
        finish        = 1'b0;
        drop          = 1'b0;
        reissue       = 1'b0;

        // Shared acknowledge/timeout handling for both wait states.
        if (state_q == StBootWait || state_q == StWait) begin
            if (!C_Rdy) begin
                finish = 1'b1;
            end else if (wait_cnt_q == LastWaitCnt) begin
                if (retry_ok) begin
                    reissue = 1'b1;
                end else begin
                    drop   = 1'b1;
                    finish = 1'b1;
                end
            end else begin
                wait_cnt_d = wait_cnt_q + 1'b1;
            end
        end

        unique case (state_q)
            StBootIssue: begin
                c_valid_d  = 1'b0;
                c_addr_d   = boot_addr;
                c_data_d   = boot_data;
                wait_cnt_d = '0;
                state_d    = StBootWait;
            end
            StBootWait: begin
                if (reissue) begin
                    state_d = StBootIssue;
                end else if (finish) begin
                    if (boot_idx_q == BootLast) begin
                        boot_done_d = 1'b1;
                        state_d     = StIdle;
                    end else begin
                        boot_idx_d = boot_idx_q + 3'd1;
                        state_d    = StBootIssue;
                    end
                end
            end
            StIdle: begin
                if (Req_A_Valid || Req_B_Valid) begin
                    rr_d      = grant_b;
                    c_addr_d  = grant_b ? Req_B_Addr : Req_A_Addr;
                    c_data_d  = grant_b ? Req_B_Data : Req_A_Data;
                    ack_a_d   = !grant_b;
                    ack_b_d   = grant_b;
                    c_valid_d = 1'b0;
                    state_d   = StIssue;
                end
            end
            StIssue: begin
                wait_cnt_d = '0;
                state_d    = StWait;
            end
            StWait: begin
                if (reissue) begin
                    c_valid_d = 1'b0;
                    state_d   = StIssue;
                end else if (finish) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (drop) begin
            err_timeout_d = 1'b1;
            if (err_count_q != 4'hF) begin
                err_count_d = err_count_q + 4'd1;
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q       <= StBootIssue;
            boot_idx_q    <= '0;
            rr_q          <= 1'b0;
            wait_cnt_q    <= '0;
            c_addr_q      <= '0;
            c_data_q      <= '0;
            c_valid_q     <= 1'b1;
            ack_a_q       <= 1'b0;
            ack_b_q       <= 1'b0;
            err_timeout_q <= 1'b0;
            err_count_q   <= '0;
            boot_done_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            boot_idx_q    <= boot_idx_d;
            rr_q          <= rr_d;
            wait_cnt_q    <= wait_cnt_d;
            c_addr_q      <= c_addr_d;
            c_data_q      <= c_data_d;
            c_valid_q     <= c_valid_d;
            ack_a_q       <= ack_a_d;
            ack_b_q       <= ack_b_d;
            err_timeout_q <= err_timeout_d;
            err_count_q   <= err_count_d;
            boot_done_q   <= boot_done_d;
        end
    end

    assign C_Addr      = c_addr_q;
    assign C_Data      = c_data_q;
    assign C_Valid     = c_valid_q;
    assign Req_A_Ack   = ack_a_q;
    assign Req_B_Ack   = ack_b_q;
    assign Err_Timeout = err_timeout_q;
    assign Err_Count   = err_count_q;
    assign Boot_Done   = boot_done_q;
    assign Busy        = (state_q != StIdle);

endmodule

// File: tb/tb_cm_config_sequencer.sv
// Directed self-checking bench for cm_config_sequencer.
// Honours CM_CFG_RETRY_EN when computing timeout expectations.
module tb_cm_config_sequencer;

    logic        clk;
    logic        rst;
    logic        req_a_valid;
    logic [3:0]  req_a_addr;
    logic [15:0] req_a_data;
    logic        req_a_ack;
    logic        req_b_valid;
    logic [3:0]  req_b_addr;
    logic [15:0] req_b_data;
    logic        req_b_ack;
    logic [3:0]  c_addr;
    logic [15:0] c_data;
    logic        c_valid;
    logic        c_rdy = 1'b1;
    logic        busy;
    logic        boot_done;
    logic        err_timeout;
    logic [3:0]  err_count;

    logic        ack_en;
    logic        bus_v;
    logic        bus_en;

    int checks   = 0;
    int failures = 0;

    logic [3:0]  log_addr [256];
    logic [15:0] log_data [256];
    int          n_strobe = 0;
    int          n_ack_a  = 0;
    int          n_ack_b  = 0;

    logic [3:0]  exp_boot_addr [6] = '{4'd1, 4'd2, 4'd2, 4'd2, 4'd2, 4'd3};
    logic [15:0] exp_boot_data [6] = '{16'h0000, 16'h3FFF, 16'h4FC0, 16'h803F, 16'hC000,
                                       16'h0003};

`ifdef CM_CFG_RETRY_EN
    localparam int ExpStrobes = 3;
    localparam int ExpDropCyc = 48;
`else
    localparam int ExpStrobes = 1;
    localparam int ExpDropCyc = 16;
`endif

    cm_config_sequencer dut (
        .Clk         (clk),
        .Rst         (rst),
        .Req_A_Valid (req_a_valid),
        .Req_A_Addr  (req_a_addr),
        .Req_A_Data  (req_a_data),
        .Req_A_Ack   (req_a_ack),
        .Req_B_Valid (req_b_valid),
        .Req_B_Addr  (req_b_addr),
        .Req_B_Data  (req_b_data),
        .Req_B_Ack   (req_b_ack),
        .C_Addr      (c_addr),
        .C_Data      (c_data),
        .C_Valid     (c_valid),
        .C_Rdy       (c_rdy),
        .Busy        (busy),
        .Boot_Done   (boot_done),
        .Err_Timeout (err_timeout),
        .Err_Count   (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bus model: acknowledges (active-low) in the cycle after a strobe when ack_en is set.
    always @(posedge clk) begin
        bus_v  = c_valid;
        bus_en = ack_en;
        #1;
        c_rdy = !(bus_v === 1'b0 && bus_en);
    end

    // Strobe and acknowledge logger.
    always @(posedge clk) begin
        if (c_valid === 1'b0) begin
            log_addr[n_strobe % 256] <= c_addr;
            log_data[n_strobe % 256] <= c_data;
            n_strobe <= n_strobe + 1;
        end
        if (req_a_ack === 1'b1) n_ack_a <= n_ack_a + 1;
        if (req_b_ack === 1'b1) n_ack_b <= n_ack_b + 1;
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (c_valid !== 1'b1 || c_addr !== 4'd0 || c_data !== 16'd0) begin
            failures++;
            $display("FAIL reset_bus: valid=%b addr=%h data=%h required 1/0/0000",
                     c_valid, c_addr, c_data);
        end
        checks++;
        if (req_a_ack !== 1'b0 || req_b_ack !== 1'b0) begin
            failures++;
            $display("FAIL reset_ack: a=%b b=%b required 0/0", req_a_ack, req_b_ack);
        end
        checks++;
        if (err_timeout !== 1'b0 || err_count !== 4'd0) begin
            failures++;
            $display("FAIL reset_err: pulse=%b count=%0d required 0/0", err_timeout, err_count);
        end
        checks++;
        if (boot_done !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL reset_status: boot_done=%b busy=%b required 0/1", boot_done, busy);
        end
    endtask

    task automatic test_boot();
        int  base;
        bit  done;
        base = n_strobe;
        rst  = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (boot_done === 1'b1) done = 1'b1;
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL boot_done: boot_done=%b required 1 within 100 cycles", boot_done);
        end
        checks++;
        if (n_strobe - base !== 6) begin
            failures++;
            $display("FAIL boot_strobes: count=%0d required 6", n_strobe - base);
        end
        for (int i = 0; i < 6; i++) begin
            if (i < n_strobe - base) begin
                checks++;
                if (log_addr[(base + i) % 256] !== exp_boot_addr[i] ||
                    log_data[(base + i) % 256] !== exp_boot_data[i]) begin
                    failures++;
                    $display("FAIL boot_entry%0d: addr=%h data=%h required %h/%h", i,
                             log_addr[(base + i) % 256], log_data[(base + i) % 256],
                             exp_boot_addr[i], exp_boot_data[i]);
                end
            end
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL boot_busy: busy=%b required 0", busy);
        end
    endtask

    task automatic test_round_robin();
        int          cyc, last_cyc, grants, base_a, base_b;
        logic        ptr_b, exp_b, got_b;
        logic [15:0] a_dat, b_dat;
        logic [3:0]  held_addr;
        ack_en      = 1'b1;
        base_a      = n_ack_a;
        base_b      = n_ack_b;
        ptr_b       = 1'b0;
        a_dat       = 16'hA000;
        b_dat       = 16'hB000;
        held_addr   = 4'd0;
        req_a_addr  = 4'd5;
        req_a_data  = a_dat;
        req_b_addr  = 4'd6;
        req_b_data  = b_dat;
        req_a_valid = 1'b1;
        req_b_valid = 1'b1;
        cyc         = 0;
        last_cyc    = 0;
        grants      = 0;
        while (grants < 4 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (req_a_ack === 1'b1 || req_b_ack === 1'b1) begin
                got_b = req_b_ack;
                exp_b = !ptr_b;
                checks++;
                if (got_b !== exp_b || req_a_ack === req_b_ack) begin
                    failures++;
                    $display("FAIL rr_grant%0d: ack_a=%b ack_b=%b required ack_b=%b only",
                             grants, req_a_ack, req_b_ack, exp_b);
                end
                checks++;
                if (c_valid !== 1'b0 || c_addr !== (exp_b ? 4'd6 : 4'd5) ||
                    c_data !== (exp_b ? b_dat : a_dat)) begin
                    failures++;
                    $display("FAIL rr_strobe%0d: valid=%b addr=%h data=%h required 0/%h/%h",
                             grants, c_valid, c_addr, c_data, exp_b ? 4'd6 : 4'd5,
                             exp_b ? b_dat : a_dat);
                end
                if (grants > 0) begin
                    checks++;
                    if (cyc - last_cyc !== 3) begin
                        failures++;
                        $display("FAIL rr_spacing%0d: gap=%0d required 3", grants,
                                 cyc - last_cyc);
                    end
                end
                last_cyc  = cyc;
                grants++;
                ptr_b     = exp_b;
                held_addr = exp_b ? 4'd6 : 4'd5;
                if (grants == 4) begin
                    req_a_valid = 1'b0;
                    req_b_valid = 1'b0;
                end else if (exp_b) begin
                    b_dat      = b_dat + 16'd1;
                    req_b_data = b_dat;
                end else begin
                    a_dat      = a_dat + 16'd1;
                    req_a_data = a_dat;
                end
            end
        end
        req_a_valid = 1'b0;
        req_b_valid = 1'b0;
        checks++;
        if (grants !== 4) begin
            failures++;
            $display("FAIL rr_timeout: grants=%0d required 4", grants);
        end
        @(negedge clk);
        checks++;
        if (c_valid !== 1'b1 || c_addr !== held_addr) begin
            failures++;
            $display("FAIL rr_hold: valid=%b addr=%h required 1/%h", c_valid, c_addr, held_addr);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (n_ack_a - base_a !== 2 || n_ack_b - base_b !== 2) begin
            failures++;
            $display("FAIL rr_ack_count: a=%0d b=%0d required 2/2", n_ack_a - base_a,
                     n_ack_b - base_b);
        end
    endtask

    task automatic test_timeout();
        int base, cyc;
        bit seen;
        ack_en      = 1'b0;
        req_b_addr  = 4'd3;
        req_b_data  = 16'h0002;
        req_b_valid = 1'b1;
        base        = n_strobe;
        seen        = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (req_b_ack === 1'b1) seen = 1'b1;
        end
        req_b_valid = 1'b0;
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL to_ack: req_b_ack=%b required 1 within 30 cycles", req_b_ack);
        end
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (err_timeout === 1'b1) seen = 1'b1;
        end
        checks++;
        if (cyc !== ExpDropCyc) begin
            failures++;
            $display("FAIL to_latency: cycles=%0d required %0d", cyc, ExpDropCyc);
        end
        checks++;
        if (n_strobe - base !== ExpStrobes) begin
            failures++;
            $display("FAIL to_strobes: count=%0d required %0d", n_strobe - base, ExpStrobes);
        end
        checks++;
        if (err_count !== 4'd1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL to_status: count=%0d busy=%b required 1/0", err_count, busy);
        end
        @(negedge clk);
        checks++;
        if (err_timeout !== 1'b0) begin
            failures++;
            $display("FAIL to_pulse_width: pulse=%b required 0", err_timeout);
        end
    endtask

    task automatic test_err_saturation();
        bit seen;
        ack_en = 1'b0;
        for (int k = 2; k <= 16; k++) begin
            req_a_addr  = 4'd1;
            req_a_data  = 16'(k);
            req_a_valid = 1'b1;
            seen        = 1'b0;
            for (int i = 0; i < 30 && !seen; i++) begin
                @(negedge clk);
                if (req_a_ack === 1'b1) seen = 1'b1;
            end
            req_a_valid = 1'b0;
            seen        = 1'b0;
            for (int i = 0; i < 200 && !seen; i++) begin
                @(negedge clk);
                if (err_timeout === 1'b1) seen = 1'b1;
            end
            checks++;
            if (!seen || err_count !== ((k > 15) ? 4'd15 : 4'(k))) begin
                failures++;
                $display("FAIL sat_drop%0d: pulse_seen=%b count=%0d required 1/%0d", k, seen,
                         err_count, (k > 15) ? 15 : k);
            end
        end
    endtask

    task automatic test_reset_mid_write();
        int base_a, base_s;
        bit seen;
        ack_en      = 1'b0;
        req_a_addr  = 4'd2;
        req_a_data  = 16'h5555;
        req_a_valid = 1'b1;
        seen        = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (req_a_ack === 1'b1) seen = 1'b1;
        end
        req_a_valid = 1'b0;
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL mid_ack: req_a_ack=%b required 1 within 30 cycles", req_a_ack);
        end
        repeat (2) @(negedge clk);
        base_a = n_ack_a;
        rst    = 1'b1;
        ack_en = 1'b1;
        @(negedge clk);
        checks++;
        if (c_valid !== 1'b1 || boot_done !== 1'b0 || err_count !== 4'd0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset: valid=%b boot_done=%b count=%0d busy=%b required 1/0/0/1",
                     c_valid, boot_done, err_count, busy);
        end
        base_s = n_strobe;
        rst    = 1'b0;
        @(negedge clk);
        checks++;
        if (c_valid !== 1'b0 || c_addr !== 4'd1 || c_data !== 16'h0000) begin
            failures++;
            $display("FAIL mid_reboot: valid=%b addr=%h data=%h required 0/1/0000",
                     c_valid, c_addr, c_data);
        end
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (boot_done === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen || n_strobe - base_s !== 6 || n_ack_a !== base_a) begin
            failures++;
            $display("FAIL mid_recover: boot_done=%b strobes=%0d extra_acks=%0d required 1/6/0",
                     boot_done, n_strobe - base_s, n_ack_a - base_a);
        end
    endtask

    task automatic test_boot_holdoff();
        bit done, early;
        rst         = 1'b1;
        req_a_addr  = 4'd2;
        req_a_data  = 16'h1234;
        req_a_valid = 1'b1;
        repeat (2) @(negedge clk);
        rst   = 1'b0;
        done  = 1'b0;
        early = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (req_a_ack === 1'b1) early = 1'b1;
            if (boot_done === 1'b1) done = 1'b1;
        end
        checks++;
        if (!done || early) begin
            failures++;
            $display("FAIL holdoff_boot: boot_done=%b early_ack=%b required 1/0", done, early);
        end
        @(negedge clk);
        checks++;
        if (req_a_ack !== 1'b1 || c_valid !== 1'b0 || c_addr !== 4'd2 ||
            c_data !== 16'h1234) begin
            failures++;
            $display("FAIL holdoff_grant: ack=%b valid=%b addr=%h data=%h required 1/0/2/1234",
                     req_a_ack, c_valid, c_addr, c_data);
        end
        req_a_valid = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        rst         = 1'b1;
        ack_en      = 1'b1;
        req_a_valid = 1'b0;
        req_a_addr  = 4'd0;
        req_a_data  = 16'd0;
        req_b_valid = 1'b0;
        req_b_addr  = 4'd0;
        req_b_data  = 16'd0;
        test_reset();
        test_boot();
        test_round_robin();
        test_timeout();
        test_err_saturation();
        test_reset_mid_write();
        test_boot_holdoff();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
